// File: rtl/l0_ctrl_if.sv
//======================================================================
// Module : l0_ctrl_if
// Brief  : Handshake/bus bundle between l0_ctrl, the image buffer,
//          layer_0 and the host.
// Rev    : 1.0
//======================================================================
`default_nettype none

interface l0_ctrl_if #(
    parameter int IMG_W = 28,
    parameter int PIX_W = 2
);
    logic                     frame_start;
    logic                     tx_done;
    logic                     img_rd;
    logic [4:0]               img_addr;
    logic [IMG_W*PIX_W-1:0]   img_data;
    logic                     l0_strt;
    logic [9*PIX_W-1:0]       l0_din;
    logic                     l0_addr_inc;
    logic                     l0_tx_done;
    logic                     busy;
    logic                     frame_done;
    logic [9:0]               out_cnt;
    logic                     err;

    modport slave (
        input  frame_start, tx_done, img_data, l0_addr_inc,
        output img_rd, img_addr, l0_strt, l0_din, l0_tx_done,
               busy, frame_done, out_cnt, err
    );

    modport master (
        output frame_start, tx_done, img_data, l0_addr_inc,
        input  img_rd, img_addr, l0_strt, l0_din, l0_tx_done,
               busy, frame_done, out_cnt, err
    );
endinterface

`default_nettype wire

// File: rtl/l0_ctrl.sv
//======================================================================
// Module : l0_ctrl
// Brief  : Layer-0 frame scheduler: 3-row sliding window over the image
//          buffer, one 3x3 window per layer_0 start/addr_inc handshake.
//          Optional watchdog enabled by defining L0_CTRL_WDOG_EN.
// Rev    : 1.0
//======================================================================
`default_nettype none

module l0_ctrl #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int PIX_W = 2
) (
    input  wire logic   clk,
    input  wire logic   rst,
    l0_ctrl_if.slave    bus
);
    localparam int         ROW_W  = IMG_W * PIX_W;
    localparam logic [4:0] C_LAST = 5'(IMG_W - 3);
    localparam logic [4:0] R_LAST = 5'(IMG_H - 3);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_HOLD  = 3'd5;

    logic [2:0]       r_state;
    logic [ROW_W-1:0] r_rows [3];
    logic [4:0]       r_r;
    logic [4:0]       r_c;
    logic [1:0]       r_rem;
    logic             r_cap;
    logic             r_frame_done;
    logic             r_tx_done;
    logic [9:0]       r_out_cnt;
    logic             w_wdog_trip;
    logic             w_err;
    logic [9*PIX_W-1:0] w_din;

`ifdef L0_CTRL_WDOG_EN
    logic [3:0] r_wdog;
    logic       r_err;

    // Counter starts at 1 in ISSUE so the trip lands 8 cycles after l0_strt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == S_ISSUE)
                r_wdog <= 4'd1;
            else if (r_state == S_WAIT && !bus.l0_addr_inc)
                r_wdog <= r_wdog + 4'd1;
            if (r_state == S_IDLE && bus.frame_start)
                r_err <= 1'b0;
            else if (w_wdog_trip)
                r_err <= 1'b1;
        end
    end

    assign w_wdog_trip = (r_state == S_WAIT) && !bus.l0_addr_inc && (r_wdog == 4'd7);
    assign w_err       = r_err;
`else
    assign w_wdog_trip = 1'b0;
    assign w_err       = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rows[0]    <= '0;
            r_rows[1]    <= '0;
            r_rows[2]    <= '0;
            r_r          <= '0;
            r_c          <= '0;
            r_rem        <= '0;
            r_cap        <= 1'b0;
            r_frame_done <= 1'b0;
            r_tx_done    <= 1'b0;
            r_out_cnt    <= '0;
        end else begin
            r_cap        <= (r_state == S_FETCH);
            r_frame_done <= 1'b0;
            r_tx_done    <= 1'b0;
            // Shifting three words in from any state yields R0,R1,R2 in fetch order.
            if (r_cap) begin
                r_rows[0] <= r_rows[1];
                r_rows[1] <= r_rows[2];
                r_rows[2] <= bus.img_data;
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.frame_start) begin
                        r_r       <= '0;
                        r_c       <= '0;
                        r_out_cnt <= '0;
                        r_rem     <= 2'd3;
                        r_state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_rem <= r_rem - 2'd1;
                    if (r_rem == 2'd1)
                        r_state <= S_DRAIN;
                end
                S_DRAIN: r_state <= S_ISSUE;
                S_ISSUE: r_state <= S_WAIT;
                S_WAIT: begin
                    if (w_wdog_trip) begin
                        r_tx_done <= 1'b1;
                        r_state   <= S_IDLE;
                    end else if (bus.l0_addr_inc) begin
                        r_out_cnt <= r_out_cnt + 10'd1;
                        if (r_c < C_LAST) begin
                            r_c     <= r_c + 5'd1;
                            r_state <= S_ISSUE;
                        end else if (r_r < R_LAST) begin
                            r_c     <= '0;
                            r_r     <= r_r + 5'd1;
                            r_rem   <= 2'd1;
                            r_state <= S_FETCH;
                        end else begin
                            r_frame_done <= 1'b1;
                            r_state      <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.tx_done) begin
                        r_tx_done <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Window is a pure mux of row registers and column; it only changes outside ISSUE/WAIT.
    always_comb begin
        w_din = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w_din[PIX_W*(3*i+j) +: PIX_W] = r_rows[i][PIX_W*(int'(r_c)+j) +: PIX_W];
            end
        end
    end

    // Refill has one row remaining, so r+3-remaining also gives r+2 there.
    assign bus.img_rd     = (r_state == S_FETCH);
    assign bus.img_addr   = (r_state == S_FETCH) ? (r_r + 5'd3 - {3'b000, r_rem}) : 5'd0;
    assign bus.l0_strt    = (r_state == S_ISSUE);
    assign bus.l0_din     = w_din;
    assign bus.l0_tx_done = r_tx_done;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.frame_done = r_frame_done;
    assign bus.out_cnt    = r_out_cnt;
    assign bus.err        = w_err;

endmodule

`default_nettype wire

// File: tb/tb_l0_ctrl.sv
//======================================================================
// Module : tb_l0_ctrl
// Brief  : Scoreboard bench for l0_ctrl with image buffer and layer_0
//          behavioural models.
// Rev    : 1.0
//======================================================================
`default_nettype none

module tb_l0_ctrl;
    localparam int W = 28;
    localparam int H = 28;
    localparam int P = 2;

    typedef struct {
        logic [17:0] win;
        int          idx;
    } exp_t;

    logic clk;
    logic rst;
    l0_ctrl_if #(.IMG_W(W), .PIX_W(P)) bus ();

    l0_ctrl #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   t0 = 0;
    bit   tchk = 0;
    int   n_strt = 0;
    int   n_fd = 0;
    int   n_txd = 0;
    bit   exp_txd = 0;
    int   exp_txd_cyc = 0;
    bit   rnd_lat = 0;
    bit   l0_stall = 0;
    int   l0_cnt = 0;
    bit   pend = 0;
    int   pend_a = 0;
    logic [1:0] img [H][W];
    int   q_addr[$];
    exp_t q_win[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W*P-1:0] row_word(input int a);
        logic [W*P-1:0] w;
        w = '0;
        for (int x = 0; x < W; x++) w[P*x +: P] = img[a][x];
        return w;
    endfunction

    function automatic logic [17:0] win_at(input int r, input int c);
        logic [17:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[P*(3*i+j) +: P] = img[r+i][c+j];
        return w;
    endfunction

    task automatic fill_img(input bit random_pix);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = random_pix ? 2'($urandom_range(0, 3)) : 2'((x + y) % 4);
    endtask

    // Image buffer: word for the address read in cycle n appears in cycle n+1.
    always @(negedge clk) begin
        if (pend) bus.img_data = row_word(pend_a);
        else      bus.img_data = 56'({$urandom, $urandom});
        pend   = bus.img_rd;
        pend_a = int'(bus.img_addr);
    end

    // layer_0: addr_inc a fixed or random number of cycles after l0_strt.
    always @(negedge clk) begin
        bus.l0_addr_inc = 1'b0;
        if (l0_cnt > 0) begin
            l0_cnt--;
            if (l0_cnt == 0) bus.l0_addr_inc = 1'b1;
        end
        if (bus.l0_strt && !l0_stall && !rst)
            l0_cnt = rnd_lat ? $urandom_range(2, 5) : 2;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.img_rd) begin
                if (q_addr.size() == 0) chk("unexpected_img_rd", 1, 0);
                else chk("img_addr", bus.img_addr, q_addr.pop_front());
            end
            if (bus.l0_strt) begin
                exp_t e;
                n_strt++;
                if (tchk && n_strt == 1) chk("first_strt_cycle", cyc - t0 + 1, 5);
                if (q_win.size() == 0) chk("unexpected_strt", 1, 0);
                else begin
                    e = q_win.pop_front();
                    chk("l0_din", bus.l0_din, e.win);
                    chk("out_cnt_at_strt", bus.out_cnt, e.idx);
                end
            end
            if (bus.frame_done) begin
                n_fd++;
                chk("out_cnt_at_done", bus.out_cnt, 676);
                chk("strt_count", n_strt, 676);
                chk("windows_left", q_win.size(), 0);
                chk("err_at_done", bus.err, 0);
                if (tchk) chk("frame_done_cycle", cyc - t0 + 1, 2083);
            end
            if (bus.l0_tx_done) begin
                n_txd++;
                chk("l0_tx_done_expected", 1, exp_txd);
                if (exp_txd) chk("l0_tx_done_cycle", cyc, exp_txd_cyc);
                exp_txd = 0;
            end
        end
    end

    task automatic start_frame(input bit tim);
        @(negedge clk);
        chk("idle_before_start", bus.busy, 0);
        q_addr.delete();
        q_win.delete();
        n_strt = 0;
        tchk   = tim;
        for (int a = 0; a < H; a++) q_addr.push_back(a);
        for (int r = 0; r < H - 2; r++)
            for (int c = 0; c < W - 2; c++)
                q_win.push_back('{win_at(r, c), r * (W - 2) + c});
        bus.frame_start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        bus.frame_start = 1'b0;
    endtask

    task automatic wait_fd(input int prev);
        for (int i = 0; i < 8000 && n_fd == prev; i++) @(negedge clk);
        chk("frame_done_seen", n_fd - prev, 1);
    endtask

    task automatic wait_strt(input int n);
        for (int i = 0; i < 4000 && n_strt < n; i++) @(negedge clk);
        chk("strt_reached", n_strt >= n, 1);
    endtask

    // Drive tx_done (optionally with frame_start) for one cycle and expect one l0_tx_done.
    task automatic host_tx_done(input bit with_start);
        int prev;
        prev = n_txd;
        @(negedge clk);
        bus.tx_done     = 1'b1;
        bus.frame_start = with_start;
        exp_txd         = 1;
        exp_txd_cyc     = cyc + 1;
        @(negedge clk);
        bus.tx_done     = 1'b0;
        bus.frame_start = 1'b0;
        repeat (5) @(negedge clk);
        chk("tx_done_pulses", n_txd - prev, 1);
        chk("idle_after_tx_done", bus.busy, 0);
    endtask

    initial begin
        int fd0;
        rst             = 1'b1;
        bus.frame_start = 1'b0;
        bus.tx_done     = 1'b0;
        bus.l0_addr_inc = 1'b0;
        bus.img_data    = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bus.img_rd, bus.img_addr, bus.l0_strt, bus.l0_din,
                              bus.l0_tx_done, bus.busy, bus.frame_done, bus.err}, 0);
        chk("reset_out_cnt", bus.out_cnt, 0);
        rst = 1'b0;

        // Diagonal pattern, fixed 2-cycle layer_0, cycle-exact timing.
        fill_img(0);
        rnd_lat = 0;
        fd0 = n_fd;
        start_frame(1);
        wait_fd(fd0);
        repeat (4) @(negedge clk);
        chk("hold_busy", bus.busy, 1);
        chk("hold_out_cnt", bus.out_cnt, 676);
        host_tx_done(0);

        // Random image, random latency, ignored tx_done/frame_start mid-frame.
        fill_img(1);
        rnd_lat = 1;
        fd0 = n_fd;
        start_frame(0);
        wait_strt(50);
        for (int i = 0; i < 20 && !bus.l0_strt; i++) @(negedge clk);
        chk("in_issue", bus.l0_strt, 1);
        bus.tx_done = 1'b1;
        @(negedge clk);
        bus.tx_done     = 1'b0;
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        wait_fd(fd0);
        host_tx_done(1);
        chk("no_new_frame_reads", q_addr.size(), 0);

        // Mid-frame reset at output 300, then a clean frame.
        fill_img(1);
        rnd_lat = 0;
        start_frame(0);
        wait_strt(300);
        rst = 1'b1;
        #1;
        chk("midrst_outputs", {bus.img_rd, bus.img_addr, bus.l0_strt, bus.l0_din,
                               bus.l0_tx_done, bus.busy, bus.frame_done, bus.err}, 0);
        chk("midrst_out_cnt", bus.out_cnt, 0);
        q_addr.delete();
        q_win.delete();
        l0_cnt = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        fill_img(1);
        rnd_lat = 1;
        fd0 = n_fd;
        start_frame(0);
        wait_fd(fd0);
        host_tx_done(0);

`ifdef L0_CTRL_WDOG_EN
        begin
            int tx0;
            l0_stall = 1;
            rnd_lat  = 0;
            tx0      = n_txd;
            start_frame(0);
            exp_txd     = 1;
            exp_txd_cyc = t0 + 12;
            for (int i = 0; i < 60 && n_txd == tx0; i++) @(negedge clk);
            chk("wdog_tx_done", n_txd - tx0, 1);
            chk("wdog_err", bus.err, 1);
            chk("wdog_idle", bus.busy, 0);
            l0_stall = 0;
            fd0 = n_fd;
            start_frame(1);
            wait_strt(1);
            chk("err_cleared", bus.err, 0);
            wait_fd(fd0);
            host_tx_done(0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
